// File: rtl/memory_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_unit
// Description : Registers load/store requests toward memory, returns load
//               results to the CDB in issue order. MAU_IO_PORT_EN adds io_*.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_access_unit #(
    parameter int LQ_DEPTH = 4,
    parameter int DATA_W   = 32,
    parameter int RSV_ID_W = 4,
    parameter int INSTR_W  = 6,
    parameter int CDB_W    = RSV_ID_W + DATA_W
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic [INSTR_W-1:0]  i_opcode,
    input  logic [RSV_ID_W-1:0] i_rsv_id,
    input  logic [DATA_W-1:0]   i_address,
    input  logic [DATA_W-1:0]   i_data,
`ifdef MAU_IO_PORT_EN
    output logic                io_out_valid,
    output logic [DATA_W-1:0]   io_out_data,
    input  logic                io_out_ready,
    input  logic                io_in_valid,
    input  logic [DATA_W-1:0]   io_in_data,
    output logic                io_in_ready,
`endif
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [CDB_W-1:0]    o_cdb,
    output logic                o_cdb_valid,
    input  logic                o_cdb_ready
);

    localparam int c_PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(LQ_DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(LQ_DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W:0]   c_LQ_FULL  = (c_CNT_W + 1)'(LQ_DEPTH);

    localparam logic [INSTR_W-1:0] c_OP_LOAD    = INSTR_W'(1);
    localparam logic [INSTR_W-1:0] c_OP_LOADB   = INSTR_W'(2);
    localparam logic [INSTR_W-1:0] c_OP_LOADR   = INSTR_W'(3);
    localparam logic [INSTR_W-1:0] c_OP_LOADT   = INSTR_W'(4);
    localparam logic [INSTR_W-1:0] c_OP_LOADTB  = INSTR_W'(5);
    localparam logic [INSTR_W-1:0] c_OP_STORE   = INSTR_W'(6);
    localparam logic [INSTR_W-1:0] c_OP_STOREB  = INSTR_W'(7);
    localparam logic [INSTR_W-1:0] c_OP_STORER  = INSTR_W'(8);
    localparam logic [INSTR_W-1:0] c_OP_STORET  = INSTR_W'(9);
    localparam logic [INSTR_W-1:0] c_OP_STORETB = INSTR_W'(10);
    localparam logic [INSTR_W-1:0] c_OP_INPUT   = INSTR_W'(11);
    localparam logic [INSTR_W-1:0] c_OP_OUTPUT  = INSTR_W'(12);

    localparam logic [1:0] c_KIND_LOAD  = 2'd0;
    localparam logic [1:0] c_KIND_STORE = 2'd1;
    localparam logic [1:0] c_KIND_IN    = 2'd2;
    localparam logic [1:0] c_KIND_OUT   = 2'd3;

`ifdef MAU_IO_PORT_EN
    localparam logic c_IO_EN = 1'b1;
    logic              w_in_ok, w_out_ok;
    logic [DATA_W-1:0] w_in_data;
    assign w_in_ok   = io_in_valid;
    assign w_out_ok  = io_out_ready;
    assign w_in_data = io_in_data;
`else
    // Without the io block, I_INPUT completes immediately with zero data.
    localparam logic c_IO_EN = 1'b0;
    logic              w_in_ok, w_out_ok;
    logic [DATA_W-1:0] w_in_data;
    assign w_in_ok   = 1'b1;
    assign w_out_ok  = 1'b0;
    assign w_in_data = '0;
`endif

    logic                r_alive;
    logic                r_req_valid;
    logic [1:0]          r_req_kind;
    logic [RSV_ID_W-1:0] r_req_rsv;
    logic [DATA_W-1:0]   r_req_addr, r_req_wdata;
    logic                r_err_orphan;

    logic [RSV_ID_W-1:0] r_tag_mem [LQ_DEPTH];
    logic [c_PTR_W-1:0]  r_tag_wr, r_tag_rd;
    logic [c_CNT_W-1:0]  r_tag_cnt;
    logic [CDB_W-1:0]    r_res_mem [LQ_DEPTH];
    logic [c_PTR_W-1:0]  r_res_wr, r_res_rd;
    logic [c_CNT_W-1:0]  r_res_cnt;
    logic [c_CNT_W-1:0]  r_inflight;

    logic w_is_load, w_is_store, w_is_in, w_is_out, w_keep, w_needs_slot;
    logic w_tag_empty, w_kind_done, w_drain, w_accept, w_pending, w_lq_full;
    logic w_load_gnt, w_in_push, w_tag_pop, w_res_push, w_res_pop;
    logic [c_CNT_W:0] w_load_cnt;
    logic [CDB_W-1:0] w_res_din;
    logic [1:0]       w_kind_next;

    always_comb begin
        w_is_load  = (i_opcode == c_OP_LOAD)   || (i_opcode == c_OP_LOADB)  ||
                     (i_opcode == c_OP_LOADR)  || (i_opcode == c_OP_LOADT)  ||
                     (i_opcode == c_OP_LOADTB);
        w_is_store = (i_opcode == c_OP_STORE)  || (i_opcode == c_OP_STOREB) ||
                     (i_opcode == c_OP_STORER) || (i_opcode == c_OP_STORET) ||
                     (i_opcode == c_OP_STORETB);
        w_is_in    = (i_opcode == c_OP_INPUT);
        w_is_out   = (i_opcode == c_OP_OUTPUT) && c_IO_EN;
        w_keep       = w_is_load || w_is_store || w_is_in || w_is_out;
        w_needs_slot = w_is_load || w_is_in;
        if (w_is_load)       w_kind_next = c_KIND_LOAD;
        else if (w_is_store) w_kind_next = c_KIND_STORE;
        else if (w_is_in)    w_kind_next = c_KIND_IN;
        else                 w_kind_next = c_KIND_OUT;
    end

    assign w_tag_empty = (r_tag_cnt == '0);

    always_comb begin
        w_kind_done = 1'b0;
        case (r_req_kind)
            c_KIND_LOAD, c_KIND_STORE: w_kind_done = mem_gnt;
            // Input results may only enter the result FIFO behind every granted load.
            c_KIND_IN:                 w_kind_done = w_tag_empty && w_in_ok;
            default:                   w_kind_done = w_out_ok;
        endcase
    end

    assign w_drain    = r_req_valid && w_kind_done;
    assign w_pending  = r_req_valid && ((r_req_kind == c_KIND_LOAD) || (r_req_kind == c_KIND_IN));
    assign w_load_cnt = {1'b0, r_inflight} + {{c_CNT_W{1'b0}}, w_pending};
    assign w_lq_full  = (w_load_cnt >= c_LQ_FULL);
    assign i_ready    = r_alive && (!r_req_valid || w_drain) && !(w_needs_slot && w_lq_full);
    assign w_accept   = i_valid && i_ready;

    assign w_load_gnt = r_req_valid && (r_req_kind == c_KIND_LOAD) && mem_gnt;
    assign w_in_push  = r_req_valid && (r_req_kind == c_KIND_IN) && w_tag_empty && w_in_ok;
    assign w_tag_pop  = mem_rvalid && !w_tag_empty;
    assign w_res_push = w_tag_pop || w_in_push;
    assign w_res_pop  = o_cdb_valid && o_cdb_ready;
    assign w_res_din  = w_in_push ? CDB_W'({r_req_rsv, w_in_data})
                                  : CDB_W'({r_tag_mem[r_tag_rd], mem_rdata});

    assign mem_req     = r_req_valid && ((r_req_kind == c_KIND_LOAD) || (r_req_kind == c_KIND_STORE));
    assign mem_we      = r_req_valid && (r_req_kind == c_KIND_STORE);
    assign mem_addr    = r_req_addr;
    assign mem_wdata   = r_req_wdata;
    assign o_cdb_valid = (r_res_cnt != '0);
    assign o_cdb       = o_cdb_valid ? r_res_mem[r_res_rd] : '0;

`ifdef MAU_IO_PORT_EN
    assign io_out_valid = r_req_valid && (r_req_kind == c_KIND_OUT);
    assign io_out_data  = r_req_wdata;
    assign io_in_ready  = r_req_valid && (r_req_kind == c_KIND_IN) && w_tag_empty;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_alive      <= 1'b0;
            r_req_valid  <= 1'b0;
            r_req_kind   <= c_KIND_LOAD;
            r_req_rsv    <= '0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_err_orphan <= 1'b0;
            r_tag_wr     <= '0;
            r_tag_rd     <= '0;
            r_tag_cnt    <= '0;
            r_res_wr     <= '0;
            r_res_rd     <= '0;
            r_res_cnt    <= '0;
            r_inflight   <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_drain) r_req_valid <= 1'b0;
            if (w_accept && w_keep) begin
                r_req_valid <= 1'b1;
                r_req_kind  <= w_kind_next;
                r_req_rsv   <= i_rsv_id;
                r_req_addr  <= i_address;
                r_req_wdata <= (w_is_store || w_is_out) ? i_data : '0;
            end
            if (mem_rvalid && w_tag_empty) r_err_orphan <= 1'b1;

            if (w_load_gnt) r_tag_wr <= (r_tag_wr == c_PTR_LAST) ? '0 : r_tag_wr + c_PTR_ONE;
            if (w_tag_pop)  r_tag_rd <= (r_tag_rd == c_PTR_LAST) ? '0 : r_tag_rd + c_PTR_ONE;
            if (w_load_gnt && !w_tag_pop)      r_tag_cnt <= r_tag_cnt + c_CNT_ONE;
            else if (!w_load_gnt && w_tag_pop) r_tag_cnt <= r_tag_cnt - c_CNT_ONE;

            if (w_res_push) r_res_wr <= (r_res_wr == c_PTR_LAST) ? '0 : r_res_wr + c_PTR_ONE;
            if (w_res_pop)  r_res_rd <= (r_res_rd == c_PTR_LAST) ? '0 : r_res_rd + c_PTR_ONE;
            if (w_res_push && !w_res_pop)      r_res_cnt <= r_res_cnt + c_CNT_ONE;
            else if (!w_res_push && w_res_pop) r_res_cnt <= r_res_cnt - c_CNT_ONE;

            if ((w_load_gnt || w_in_push) && !w_res_pop)      r_inflight <= r_inflight + c_CNT_ONE;
            else if (!(w_load_gnt || w_in_push) && w_res_pop) r_inflight <= r_inflight - c_CNT_ONE;
        end
    end

    // Storage arrays need no reset: occupancy counters gate every read.
    always_ff @(posedge clk) begin
        if (w_load_gnt) r_tag_mem[r_tag_wr] <= r_req_rsv;
        if (w_res_push) r_res_mem[r_res_wr] <= w_res_din;
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access_unit
// Description : Directed vectors and sequences for memory_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access_unit;

    localparam logic [5:0] OP_LOAD = 6'd1, OP_LOADB = 6'd2, OP_LOADR = 6'd3, OP_LOADT = 6'd4;
    localparam logic [5:0] OP_LOADTB = 6'd5, OP_STORE = 6'd6, OP_STORER = 6'd8, OP_STORETB = 6'd10;
    localparam logic [5:0] OP_INPUT = 6'd11, OP_OUTPUT = 6'd12, OP_BOGUS = 6'd63;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        i_valid = 1'b0, i_ready;
    logic [5:0]  i_opcode = '0;
    logic [3:0]  i_rsv_id = '0;
    logic [31:0] i_address = '0, i_data = '0;
    logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [35:0] o_cdb;
    logic        o_cdb_valid, o_cdb_ready = 1'b0;
`ifdef MAU_IO_PORT_EN
    logic        io_out_valid, io_out_ready = 1'b0, io_in_valid = 1'b0, io_in_ready;
    logic [31:0] io_out_data, io_in_data = '0;
`endif

    always #5 clk = ~clk;

    memory_access_unit #(.LQ_DEPTH(4), .DATA_W(32), .RSV_ID_W(4), .INSTR_W(6), .CDB_W(36)) dut (
        .clk(clk), .nrst(nrst),
        .i_valid(i_valid), .i_ready(i_ready), .i_opcode(i_opcode), .i_rsv_id(i_rsv_id),
        .i_address(i_address), .i_data(i_data),
`ifdef MAU_IO_PORT_EN
        .io_out_valid(io_out_valid), .io_out_data(io_out_data), .io_out_ready(io_out_ready),
        .io_in_valid(io_in_valid), .io_in_data(io_in_data), .io_in_ready(io_in_ready),
`endif
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .o_cdb(o_cdb), .o_cdb_valid(o_cdb_valid), .o_cdb_ready(o_cdb_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " i_ready"}, i_ready, 0);
        chk({tag, " mem_req"}, mem_req, 0);
        chk({tag, " mem_we"}, mem_we, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " o_cdb"}, o_cdb, 0);
        chk({tag, " o_cdb_valid"}, o_cdb_valid, 0);
`ifdef MAU_IO_PORT_EN
        chk({tag, " io_out_valid"}, io_out_valid, 0);
        chk({tag, " io_out_data"}, io_out_data, 0);
        chk({tag, " io_in_ready"}, io_in_ready, 0);
`endif
    endtask

    task automatic issue(input logic [5:0] op, input logic [3:0] rsv, input logic [31:0] addr,
                         input logic [31:0] data);
        i_valid = 1'b1; i_opcode = op; i_rsv_id = rsv; i_address = addr; i_data = data;
        #1;
        chk("issue i_ready", i_ready, 1);
        tick;
        i_valid = 1'b0; i_opcode = '0;
    endtask

    // Issues n loads (rsv k+1, addr 0x100+k) against a small in-order memory model.
    task automatic run_loads(input int n, input bit rnd, input int hold,
                             output int issued_at_hold, output logic ready_at_hold);
        int issued = 0, popped = 0, last_due = -1;
        logic [31:0] rq_data[$];
        int rq_due[$];
        issued_at_hold = -1; ready_at_hold = 1'bx;
        for (int cyc = 0; cyc < 400 && popped < n; cyc++) begin
            mem_gnt     = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            o_cdb_ready = (cyc >= hold) ? (rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
            mem_rvalid  = (rq_due.size() > 0) && (rq_due[0] <= cyc);
            mem_rdata   = mem_rvalid ? rq_data[0] : 32'h0;
            i_valid     = (issued < n);
            i_opcode    = OP_LOAD;
            i_rsv_id    = 4'(issued + 1);
            i_address   = 32'h100 + 32'(issued);
            #1;
            if (cyc == hold - 1) begin issued_at_hold = issued; ready_at_hold = i_ready; end
            if (mem_rvalid) begin void'(rq_data.pop_front()); void'(rq_due.pop_front()); end
            if (mem_req && mem_gnt && !mem_we) begin
                int due = cyc + 1 + (rnd ? int'($urandom_range(0, 3)) : 0);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                rq_data.push_back(mem_addr ^ 32'hA5A5_0000);
                rq_due.push_back(due);
            end
            if (o_cdb_valid && o_cdb_ready) begin
                chk("order cdb", o_cdb, {4'(popped + 1), (32'h100 + 32'(popped)) ^ 32'hA5A5_0000});
                popped++;
            end
            if (i_valid && i_ready) issued++;
            tick;
        end
        chk("order all popped", popped, n);
        i_valid = 0; mem_gnt = 0; mem_rvalid = 0; o_cdb_ready = 0;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [3:0]  rsv;
        logic [31:0] addr, wdata, rdata;
        logic        exp_req, exp_we;
        logic [31:0] exp_wdata;
        logic        exp_cdb_v;
        logic [35:0] exp_cdb;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int   ih;
        logic rh;

        vecs[0] = '{OP_LOAD,    4'd3,  32'h10,        32'h1234,      32'hCAFE,      1, 0, 32'h0,         1, 36'h3_0000_CAFE};
        vecs[1] = '{OP_LOADB,   4'd9,  32'h44,        32'h0,         32'h12,        1, 0, 32'h0,         1, 36'h9_0000_0012};
        vecs[2] = '{OP_LOADTB,  4'd15, 32'hFFFF_FFFC, 32'h77,        32'hDEAD_BEEF, 1, 0, 32'h0,         1, 36'hF_DEAD_BEEF};
        vecs[3] = '{OP_STORE,   4'd2,  32'h20,        32'h55,        32'h0,         1, 1, 32'h55,        0, 36'h0};
        vecs[4] = '{OP_STORETB, 4'd0,  32'h80,        32'hA5A5_5A5A, 32'h0,         1, 1, 32'hA5A5_5A5A, 0, 36'h0};
        vecs[5] = '{OP_LOADR,   4'd0,  32'h4,         32'h0,         32'h0,         1, 0, 32'h0,         1, 36'h0_0000_0000};
        vecs[6] = '{OP_BOGUS,   4'd5,  32'h30,        32'h99,        32'h0,         0, 0, 32'h0,         0, 36'h0};
`ifdef MAU_IO_PORT_EN
        vecs[7] = '{OP_STORER,  4'd6,  32'h64,        32'h1,         32'h0,         1, 1, 32'h1,         0, 36'h0};
        vecs[8] = '{OP_LOADT,   4'd8,  32'h68,        32'h0,         32'h8888,      1, 0, 32'h0,         1, 36'h8_0000_8888};
`else
        vecs[7] = '{OP_INPUT,   4'd7,  32'h0,         32'h0,         32'h0,         0, 0, 32'h0,         1, 36'h7_0000_0000};
        vecs[8] = '{OP_OUTPUT,  4'd4,  32'h0,         32'h41,        32'h0,         0, 0, 32'h0,         0, 36'h0};
`endif

        // Reset state and first edge after release
        i_opcode = OP_LOAD;
        #1;
        chk_all_zero("reset");
        tick; tick;
        nrst = 1'b1;
        tick;
        #1;
        chk("post-reset i_ready", i_ready, 1);
        chk("post-reset err_orphan", dut.r_err_orphan, 0);
        i_opcode = '0;

        // Table-driven single transactions
        for (int v = 0; v < 9; v++) begin
            logic is_load;
            issue(vecs[v].op, vecs[v].rsv, vecs[v].addr, vecs[v].wdata);
            chk("vec mem_req", mem_req, vecs[v].exp_req);
            if (vecs[v].exp_req) begin
                chk("vec mem_we", mem_we, vecs[v].exp_we);
                chk("vec mem_addr", mem_addr, vecs[v].addr);
                chk("vec mem_wdata", mem_wdata, vecs[v].exp_wdata);
            end
            mem_gnt = vecs[v].exp_req;
            tick;
            mem_gnt = 1'b0;
            is_load = vecs[v].exp_req && !vecs[v].exp_we;
            if (is_load) begin
                mem_rvalid = 1'b1; mem_rdata = vecs[v].rdata;
                tick;
                mem_rvalid = 1'b0;
            end
            chk("vec cdb_valid", o_cdb_valid, vecs[v].exp_cdb_v);
            if (vecs[v].exp_cdb_v) chk("vec cdb", o_cdb, vecs[v].exp_cdb);
            o_cdb_ready = 1'b1;
            tick;
            o_cdb_ready = 1'b0;
            chk("vec cdb drained", o_cdb_valid, 0);
        end

        // Minimum load latency: accept N, req/gnt N+1, rvalid N+2, cdb N+3
        issue(OP_LOAD, 4'd3, 32'h10, 32'h0);
        mem_gnt = 1'b1;
        #1;
        chk("lat mem_req N+1", mem_req, 1);
        tick;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
        chk("lat cdb_valid N+2", o_cdb_valid, 0);
        tick;
        mem_rvalid = 1'b0;
        chk("lat cdb_valid N+3", o_cdb_valid, 1);
        chk("lat cdb N+3", o_cdb, 36'h3_0000_CAFE);
        tick;
        chk("lat hold valid", o_cdb_valid, 1);
        chk("lat hold cdb", o_cdb, 36'h3_0000_CAFE);
        o_cdb_ready = 1'b1;
        tick;
        o_cdb_ready = 1'b0;

        // Store held off by gnt=0 for three cycles
        issue(OP_STORE, 4'd1, 32'h20, 32'h55);
        for (int c = 0; c < 4; c++) begin
            mem_gnt = (c == 3);
            #1;
            chk("st mem_req", mem_req, 1);
            chk("st mem_we", mem_we, 1);
            chk("st mem_addr", mem_addr, 32'h20);
            chk("st mem_wdata", mem_wdata, 32'h55);
            chk("st i_ready", i_ready, (c == 3));
            chk("st cdb_valid", o_cdb_valid, 0);
            tick;
        end
        mem_gnt = 1'b0;
        chk("st done mem_req", mem_req, 0);
        tick;
        chk("st no cdb", o_cdb_valid, 0);

        // Five loads, CDB back-pressured: fifth stalls, all return in order
        run_loads(5, 1'b0, 12, ih, rh);
        chk("lq issued at stall", ih, 4);
        chk("lq i_ready at stall", rh, 0);

        // Ten loads with random grant/return timing wrap both FIFOs
        run_loads(10, 1'b1, 0, ih, rh);

        // Reset with loads outstanding
        issue(OP_LOAD, 4'd1, 32'h200, 32'h0);
        mem_gnt = 1'b1; tick; mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111;
        issue(OP_LOAD, 4'd2, 32'h204, 32'h0);
        mem_rvalid = 1'b0;
        mem_gnt = 1'b1; tick; mem_gnt = 1'b0;
        issue(OP_LOAD, 4'd3, 32'h208, 32'h0);
        chk("pre-rst cdb_valid", o_cdb_valid, 1);
        chk("pre-rst mem_req", mem_req, 1);
        i_opcode = OP_LOAD;
        nrst = 1'b0;
        #1;
        chk_all_zero("mid-reset");
        tick;
        nrst = 1'b1;
        tick;
        chk("rst err_orphan clear", dut.r_err_orphan, 0);
        chk("rst i_ready", i_ready, 1);
        i_opcode = '0;
        mem_rvalid = 1'b1; mem_rdata = 32'h2222;
        tick;
        mem_rvalid = 1'b0;
        chk("orphan flag", dut.r_err_orphan, 1);
        chk("orphan no cdb", o_cdb_valid, 0);
        tick;
        chk("orphan no cdb later", o_cdb_valid, 0);
        chk("orphan sticky", dut.r_err_orphan, 1);

`ifdef MAU_IO_PORT_EN
        issue(OP_OUTPUT, 4'd0, 32'h0, 32'h41);
        chk("io_out valid", io_out_valid, 1);
        chk("io_out data", io_out_data, 32'h41);
        chk("io_out no mem", mem_req, 0);
        tick;
        chk("io_out hold", io_out_valid, 1);
        io_out_ready = 1'b1;
        tick;
        io_out_ready = 1'b0;
        chk("io_out done", io_out_valid, 0);
        issue(OP_INPUT, 4'd7, 32'h0, 32'h0);
        chk("io_in ready", io_in_ready, 1);
        tick;
        chk("io_in waits", o_cdb_valid, 0);
        io_in_valid = 1'b1; io_in_data = 32'h42;
        tick;
        io_in_valid = 1'b0;
        chk("io_in cdb_valid", o_cdb_valid, 1);
        chk("io_in cdb", o_cdb, 36'h7_0000_0042);
        o_cdb_ready = 1'b1;
        tick;
        o_cdb_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
